// File: rtl/amo_ctrl_if.sv
// amo_ctrl_if: bundles the execute-side atomic handshake, the data-memory port
// and the reservation snoop/clear inputs of the atomic sequencer.
//  slave  : the view used by amo_ctrl (drives amo_*_o and mem_*_o)
//  master : the view used by the environment (execute stage, memory, snoop)
interface amo_ctrl_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // execute stage side
  logic          amo_valid_i;
  logic          amo_ready_o;
  logic [4:0]    amo_funct5_i;
  logic [AW-1:0] amo_addr_i;
  logic [DW-1:0] amo_wdata_i;
  logic          amo_done_o;
  logic [DW-1:0] amo_rdata_o;
  logic          amo_err_o;
  logic          amo_busy_o;
  // data-memory port
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_gnt_i;
  logic          mem_rvalid_i;
  logic [DW-1:0] mem_rdata_i;
  // reservation maintenance
  logic          snoop_st_i;
  logic [AW-1:0] snoop_addr_i;
  logic          resv_clr_i;

  modport slave (
    input  amo_valid_i, amo_funct5_i, amo_addr_i, amo_wdata_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  snoop_st_i, snoop_addr_i, resv_clr_i,
    output amo_ready_o, amo_done_o, amo_rdata_o, amo_err_o, amo_busy_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output amo_valid_i, amo_funct5_i, amo_addr_i, amo_wdata_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output snoop_st_i, snoop_addr_i, resv_clr_i,
    input  amo_ready_o, amo_done_o, amo_rdata_o, amo_err_o, amo_busy_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/amo_ctrl.sv
// amo_ctrl: sequences RV32A LR.W / SC.W / AMO*.W between execute and one
// data-memory port, and holds the single LR/SC reservation.
// Ports:
//  clk_i  : clock, all flops on the rising edge
//  rst_i  : asynchronous active-high reset
//  bus    : amo_ctrl_if.slave -- execute handshake (amo_*), memory port
//           (mem_*), store snoop and reservation clear
// One memory transaction is outstanding at a time; requests are held with
// stable address/data until granted.
module amo_ctrl #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic       clk_i,
  input logic       rst_i,
  amo_ctrl_if.slave bus
);

  localparam logic [4:0] F5_LR   = 5'b00010;
  localparam logic [4:0] F5_SC   = 5'b00011;
  localparam logic [4:0] F5_ADD  = 5'b00000;
  localparam logic [4:0] F5_XOR  = 5'b00100;
  localparam logic [4:0] F5_AND  = 5'b01100;
  localparam logic [4:0] F5_OR   = 5'b01000;
  localparam logic [4:0] F5_MIN  = 5'b10000;
  localparam logic [4:0] F5_MAX  = 5'b10100;
  localparam logic [4:0] F5_MINU = 5'b11000;
  localparam logic [4:0] F5_MAXU = 5'b11100;

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [4:0]      op_funct5_reg;
  logic [AW-3:0]   op_waddr_reg;      // word address of the captured op
  logic [DW-1:0]   op_wdata_reg;
  logic [DW-1:0]   old_reg;           // value read by the RMW / LR
  logic [DW-1:0]   rdata_reg;
  logic            err_reg;
  logic            resv_valid_reg;
  logic [AW-3:0]   resv_addr_reg;

  // FSM side outputs
  logic            capture;
  logic            load_old;
  logic            set_resv;
  logic            sc_clear;
  logic            finish;
  logic [DW-1:0]   finish_rdata;
  logic            finish_err;

  logic            in_is_sc;
  logic            in_misaligned;
  logic            snoop_hit;
  logic            resv_kill;
  logic            sc_ok;
  logic [DW-1:0]   alu_result;
  logic            unused_bits;

  assign unused_bits = ^bus.snoop_addr_i[1:0];

  assign in_is_sc      = (bus.amo_funct5_i == F5_SC);
  assign in_misaligned = (bus.amo_addr_i[1:0] != 2'b00);
  assign snoop_hit     = bus.snoop_st_i && (bus.snoop_addr_i[AW-1:2] == resv_addr_reg);
  assign resv_kill     = bus.resv_clr_i || snoop_hit;
  // A clear arriving in the same cycle as the SC decision makes the SC fail.
  assign sc_ok         = resv_valid_reg && !resv_kill &&
                         (resv_addr_reg == bus.amo_addr_i[AW-1:2]);

  // Write value for the RMW. SC (and any unlisted funct5) falls into the
  // default arm, which simply writes the operand.
  always_comb begin
    alu_result = op_wdata_reg;
    case (op_funct5_reg)
      F5_ADD:  alu_result = old_reg + op_wdata_reg;
      F5_XOR:  alu_result = old_reg ^ op_wdata_reg;
      F5_AND:  alu_result = old_reg & op_wdata_reg;
      F5_OR:   alu_result = old_reg | op_wdata_reg;
      F5_MIN:  alu_result = ($signed(old_reg) < $signed(op_wdata_reg)) ? old_reg : op_wdata_reg;
      F5_MAX:  alu_result = ($signed(old_reg) > $signed(op_wdata_reg)) ? old_reg : op_wdata_reg;
      F5_MINU: alu_result = (old_reg < op_wdata_reg) ? old_reg : op_wdata_reg;
      F5_MAXU: alu_result = (old_reg > op_wdata_reg) ? old_reg : op_wdata_reg;
      default: alu_result = op_wdata_reg;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and FSM side outputs
  always_comb begin
    state_next   = state_reg;
    capture      = 1'b0;
    load_old     = 1'b0;
    set_resv     = 1'b0;
    sc_clear     = 1'b0;
    finish       = 1'b0;
    finish_rdata = '0;
    finish_err   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.amo_valid_i) begin
          capture = 1'b1;
          if (in_misaligned) begin
            state_next = DONE;
            finish     = 1'b1;
            finish_err = 1'b1;
            sc_clear   = in_is_sc;
          end else if (in_is_sc) begin
            sc_clear = 1'b1;
            if (sc_ok) begin
              state_next = WR_REQ;
            end else begin
              state_next   = DONE;
              finish       = 1'b1;
              finish_rdata = {{(DW-1){1'b0}}, 1'b1};
            end
          end else begin
            state_next = RD_REQ;
          end
        end
      end
      RD_REQ: begin
        if (bus.mem_gnt_i) state_next = RD_WAIT;
      end
      RD_WAIT: begin
        if (bus.mem_rvalid_i) begin
          load_old = 1'b1;
          if (op_funct5_reg == F5_LR) begin
            set_resv     = 1'b1;
            state_next   = DONE;
            finish       = 1'b1;
            finish_rdata = bus.mem_rdata_i;
          end else begin
            state_next = WR_REQ;
          end
        end
      end
      WR_REQ: begin
        if (bus.mem_gnt_i) state_next = WR_WAIT;
      end
      WR_WAIT: begin
        if (bus.mem_rvalid_i) begin
          state_next   = DONE;
          finish       = 1'b1;
          // Only a successful SC reaches here without a read; it returns 0.
          finish_rdata = (op_funct5_reg == F5_SC) ? '0 : old_reg;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture, read data, result registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_funct5_reg <= '0;
      op_waddr_reg  <= '0;
      op_wdata_reg  <= '0;
      old_reg       <= '0;
      rdata_reg     <= '0;
      err_reg       <= 1'b0;
    end else begin
      if (capture) begin
        op_funct5_reg <= bus.amo_funct5_i;
        op_waddr_reg  <= bus.amo_addr_i[AW-1:2];
        op_wdata_reg  <= bus.amo_wdata_i;
      end
      if (load_old) old_reg <= bus.mem_rdata_i;
      if (finish) begin
        rdata_reg <= finish_rdata;
        err_reg   <= finish_err;
      end
    end
  end

  // Reservation: an LR completing wins over any clear in the same cycle.
  // The controller's own AMO write is not snooped, so it never clears it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resv_valid_reg <= 1'b0;
      resv_addr_reg  <= '0;
    end else if (set_resv) begin
      resv_valid_reg <= 1'b1;
      resv_addr_reg  <= op_waddr_reg;
    end else if (sc_clear || resv_kill) begin
      resv_valid_reg <= 1'b0;
    end
  end

  assign bus.amo_ready_o = (state_reg == IDLE);
  assign bus.amo_busy_o  = (state_reg != IDLE);
  assign bus.amo_done_o  = (state_reg == DONE);
  assign bus.amo_rdata_o = rdata_reg;
  assign bus.amo_err_o   = err_reg;
  assign bus.mem_req_o   = (state_reg == RD_REQ) || (state_reg == WR_REQ);
  assign bus.mem_we_o    = (state_reg == WR_REQ);
  assign bus.mem_addr_o  = {op_waddr_reg, 2'b00};
  assign bus.mem_wdata_o = alu_result;

endmodule

// File: tb/tb_amo_ctrl.sv
// tb_amo_ctrl: directed bench for amo_ctrl with a word-array memory responder
// that can stall grants a configurable number of cycles.
module tb_amo_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  amo_ctrl_if #(.AW(32), .DW(32)) bus ();

  amo_ctrl #(.AW(32), .DW(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  localparam logic [4:0] LR   = 5'b00010;
  localparam logic [4:0] SC   = 5'b00011;
  localparam logic [4:0] SWAP = 5'b00001;
  localparam logic [4:0] ADD  = 5'b00000;
  localparam logic [4:0] XORO = 5'b00100;
  localparam logic [4:0] ANDO = 5'b01100;
  localparam logic [4:0] ORO  = 5'b01000;
  localparam logic [4:0] MIN  = 5'b10000;
  localparam logic [4:0] MAX  = 5'b10100;
  localparam logic [4:0] MINU = 5'b11000;
  localparam logic [4:0] MAXU = 5'b11100;

  int checks = 0;
  int errors = 0;

  // memory model
  logic [31:0] mem [0:1023];
  int          stall_cfg = 0;
  int          stall_left = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_data;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;
  int          wr_count = 0;

  // op results
  logic [31:0] res;
  logic        res_err;
  int          lat;
  int          reqc;
  logic        stable;

  always @(negedge clk) begin
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    if (rst) begin
      pend       = 1'b0;
      stall_left = stall_cfg;
    end else if (pend) begin
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = pend_data;
      pend             = 1'b0;
    end else if (bus.mem_req_o) begin
      if (stall_left > 0) begin
        stall_left = stall_left - 1;
      end else begin
        bus.mem_gnt_i = 1'b1;
        pend          = 1'b1;
        stall_left    = stall_cfg;
        if (bus.mem_we_o) begin
          mem[bus.mem_addr_o[11:2]] = bus.mem_wdata_o;
          last_wr_addr = bus.mem_addr_o;
          last_wr_data = bus.mem_wdata_o;
          wr_count     = wr_count + 1;
          pend_data    = '0;
        end else begin
          pend_data = mem[bus.mem_addr_o[11:2]];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [4:0] f5, input logic [31:0] a, input logic [31:0] b);
    logic        seen_rd, seen_wr;
    logic [31:0] rd_a, wr_a, wr_d;
    seen_rd = 1'b0; seen_wr = 1'b0;
    rd_a = '0; wr_a = '0; wr_d = '0;
    @(negedge clk);
    chk("ready_before_op", {31'b0, bus.amo_ready_o}, 32'd1);
    bus.amo_valid_i  = 1'b1;
    bus.amo_funct5_i = f5;
    bus.amo_addr_i   = a;
    bus.amo_wdata_i  = b;
    @(posedge clk);
    #1;
    bus.amo_valid_i = 1'b0;
    lat = 1; reqc = 0; stable = 1'b1;
    while (lat < 100) begin
      @(negedge clk);
      if (bus.amo_done_o) break;
      if (bus.mem_req_o) begin
        reqc = reqc + 1;
        if (!bus.mem_we_o) begin
          if (!seen_rd) begin rd_a = bus.mem_addr_o; seen_rd = 1'b1; end
          else if (bus.mem_addr_o !== rd_a) stable = 1'b0;
        end else begin
          if (!seen_wr) begin wr_a = bus.mem_addr_o; wr_d = bus.mem_wdata_o; seen_wr = 1'b1; end
          else if (bus.mem_addr_o !== wr_a || bus.mem_wdata_o !== wr_d) stable = 1'b0;
        end
      end
      @(posedge clk);
      lat = lat + 1;
    end
    chk("done_within_bound", {31'b0, (lat < 100)}, 32'd1);
    res     = bus.amo_rdata_o;
    res_err = bus.amo_err_o;
    $display("op f5=%b addr=%h b=%h -> rd=%h err=%0d lat=%0d reqs=%0d", f5, a, b, res, res_err, lat, reqc);
    @(negedge clk);
    chk("done_one_cycle", {31'b0, bus.amo_done_o}, 32'd0);
    chk("rdata_held", bus.amo_rdata_o, res);
  endtask

  task automatic pulse_snoop(input logic [31:0] a);
    @(negedge clk);
    bus.snoop_st_i   = 1'b1;
    bus.snoop_addr_i = a;
    @(negedge clk);
    bus.snoop_st_i   = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[10'h040] = 32'd5;
    mem[10'h080] = 32'h11;
    mem[10'h0C0] = 32'hFFFF_FFFF;
    mem[10'h100] = 32'd7;
    mem[10'h140] = 32'd9;
    bus.amo_valid_i  = 1'b0;
    bus.amo_funct5_i = '0;
    bus.amo_addr_i   = '0;
    bus.amo_wdata_i  = '0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    bus.snoop_st_i   = 1'b0;
    bus.snoop_addr_i = '0;
    bus.resv_clr_i   = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, bus.amo_ready_o}, 32'd1);
    chk("rst_busy",  {31'b0, bus.amo_busy_o},  32'd0);
    chk("rst_done",  {31'b0, bus.amo_done_o},  32'd0);
    chk("rst_err",   {31'b0, bus.amo_err_o},   32'd0);
    chk("rst_rdata", bus.amo_rdata_o, 32'd0);
    chk("rst_req",   {31'b0, bus.mem_req_o},   32'd0);
    chk("rst_we",    {31'b0, bus.mem_we_o},    32'd0);
    rst = 1'b0;

    // AMOADD with immediate grant/ack
    do_op(ADD, 32'h100, 32'd3);
    chk("add_rd", res, 32'd5);
    chk("add_lat", lat, 32'd5);
    chk("add_err", {31'b0, res_err}, 32'd0);
    chk("add_wr_addr", last_wr_addr, 32'h100);
    chk("add_wr_data", last_wr_data, 32'd8);

    // LR then SC succeeds; a second SC fails without touching memory
    do_op(LR, 32'h200, 32'd0);
    chk("lr_rd", res, 32'h11);
    chk("lr_lat", lat, 32'd3);
    do_op(SC, 32'h200, 32'hA5);
    chk("sc_ok_rd", res, 32'd0);
    chk("sc_ok_lat", lat, 32'd3);
    chk("sc_ok_mem", mem[10'h080], 32'hA5);
    do_op(SC, 32'h200, 32'hB6);
    chk("sc2_rd", res, 32'd1);
    chk("sc2_lat", lat, 32'd1);
    chk("sc2_noreq", reqc, 32'd0);
    chk("sc2_mem", mem[10'h080], 32'hA5);

    // snoop on the same word kills the reservation
    do_op(LR, 32'h200, 32'd0);
    chk("lr2_rd", res, 32'hA5);
    pulse_snoop(32'h202);
    do_op(SC, 32'h200, 32'h77);
    chk("sc_snoop_rd", res, 32'd1);
    chk("sc_snoop_noreq", reqc, 32'd0);
    chk("sc_snoop_mem", mem[10'h080], 32'hA5);

    // resv_clr_i kills the reservation
    do_op(LR, 32'h200, 32'd0);
    @(negedge clk);
    bus.resv_clr_i = 1'b1;
    @(negedge clk);
    bus.resv_clr_i = 1'b0;
    do_op(SC, 32'h200, 32'h77);
    chk("sc_clr_rd", res, 32'd1);
    chk("sc_clr_noreq", reqc, 32'd0);
    chk("sc_clr_mem", mem[10'h080], 32'hA5);

    // snoop to a different word leaves the reservation intact
    do_op(LR, 32'h200, 32'd0);
    pulse_snoop(32'h204);
    do_op(SC, 32'h200, 32'h5A);
    chk("sc_othersnoop_rd", res, 32'd0);
    chk("sc_othersnoop_mem", mem[10'h080], 32'h5A);

    // own AMO write does not clear the reservation
    do_op(LR, 32'h400, 32'd0);
    chk("lr400_rd", res, 32'd7);
    do_op(ADD, 32'h400, 32'd1);
    chk("add400_rd", res, 32'd7);
    do_op(SC, 32'h400, 32'h33);
    chk("sc400_rd", res, 32'd0);
    chk("sc400_mem", mem[10'h100], 32'h33);

    // signed vs unsigned min, then the remaining ops
    do_op(MIN, 32'h300, 32'd1);
    chk("min_rd", res, 32'hFFFF_FFFF);
    chk("min_wr", last_wr_data, 32'hFFFF_FFFF);
    do_op(MINU, 32'h300, 32'd1);
    chk("minu_rd", res, 32'hFFFF_FFFF);
    chk("minu_wr", last_wr_data, 32'd1);
    do_op(MAX, 32'h300, 32'hFFFF_FFFE);
    chk("max_rd", res, 32'd1);
    chk("max_wr", last_wr_data, 32'd1);
    do_op(XORO, 32'h300, 32'd3);
    chk("xor_wr", last_wr_data, 32'd2);
    do_op(ORO, 32'h300, 32'hF0);
    chk("or_rd", res, 32'd2);
    chk("or_wr", last_wr_data, 32'hF2);
    do_op(ANDO, 32'h300, 32'h0F);
    chk("and_wr", last_wr_data, 32'h02);
    do_op(MAXU, 32'h300, 32'h8000_0000);
    chk("maxu_wr", last_wr_data, 32'h8000_0000);
    do_op(SWAP, 32'h300, 32'h1234);
    chk("swap_rd", res, 32'h8000_0000);
    chk("swap_mem", mem[10'h0C0], 32'h1234);

    // stalled grants in both request phases
    stall_cfg  = 4;
    stall_left = 4;
    do_op(ADD, 32'h100, 32'd2);
    chk("stall_rd", res, 32'd8);
    chk("stall_lat", lat, 32'd13);
    chk("stall_reqc", reqc, 32'd10);
    chk("stall_stable", {31'b0, stable}, 32'd1);
    chk("stall_mem", mem[10'h040], 32'd10);
    stall_cfg  = 0;
    stall_left = 0;

    // misaligned AMOSWAP
    do_op(SWAP, 32'h103, 32'hDEAD);
    chk("mis_err", {31'b0, res_err}, 32'd1);
    chk("mis_rd", res, 32'd0);
    chk("mis_lat", lat, 32'd1);
    chk("mis_noreq", reqc, 32'd0);

    // reset while in WR_WAIT drops the op and the reservation
    do_op(LR, 32'h500, 32'd0);
    chk("lr500_rd", res, 32'd9);
    @(negedge clk);
    bus.amo_valid_i  = 1'b1;
    bus.amo_funct5_i = ADD;
    bus.amo_addr_i   = 32'h500;
    bus.amo_wdata_i  = 32'd1;
    @(posedge clk);
    #1;
    bus.amo_valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ready", {31'b0, bus.amo_ready_o}, 32'd1);
    chk("midrst_busy",  {31'b0, bus.amo_busy_o},  32'd0);
    chk("midrst_req",   {31'b0, bus.mem_req_o},   32'd0);
    chk("midrst_done",  {31'b0, bus.amo_done_o},  32'd0);
    rst = 1'b0;
    do_op(SC, 32'h500, 32'h44);
    chk("sc_after_rst_rd", res, 32'd1);
    chk("sc_after_rst_noreq", reqc, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
